sram_line_packer: RTL



---
 rtl/sram_line_packer.sv | 90 +++++++++
 1 files changed

// File: rtl/sram_line_packer.sv
// sram_line_packer: packs WORD_WIDTH input words into LINE_WIDTH lines written to SRAM port A.
// Define SRAM_LINE_PACKER_FLUSH_EN to let flush write a zero-padded partial line.
module sram_line_packer #(
  parameter int LINE_WIDTH = 256,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int WPL = LINE_WIDTH / WORD_WIDTH,
  localparam int IW = $clog2(WPL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         cfg_base_addr,
  input  logic [AW:0]           cfg_lines,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  sram_enable_a_n,
  output logic                  sram_write_enable_a_n,
  output logic [AW-1:0]         sram_address_a,
  output logic [LINE_WIDTH-1:0] sram_data_a,
  output logic                  busy,
  output logic                  done,
  output logic [AW:0]           lines_written
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic [AW:0] lines_cfg;
  logic accept, flush_go;
  assign accept = in_valid && in_ready;
`ifdef SRAM_LINE_PACKER_FLUSH_EN
  assign flush_go = flush && (idx != '0 || accept);
`else
  logic flush_unused;
  assign flush_unused = flush;
  assign flush_go = 1'b0;
`endif
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = start ? (cfg_lines == '0 ? DONE : FILL) : IDLE;
      FILL:    next = (accept && idx == IW'(WPL - 1)) || flush_go ? WRITE : FILL;
      WRITE:   next = lines_written + 1'b1 == lines_cfg ? DONE : FILL;
      default: next = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      lines_cfg <= '0;
      lines_written <= '0;
      sram_address_a <= '0;
      sram_data_a <= '0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sram_enable_a_n <= 1'b1;
      sram_write_enable_a_n <= 1'b1;
    end else begin
      state <= next;
      in_ready <= next == FILL;
      busy <= next == FILL || next == WRITE;
      done <= next == DONE;
      sram_enable_a_n <= next != WRITE;
      sram_write_enable_a_n <= next != WRITE;
      if (state == IDLE && start) begin
        sram_address_a <= cfg_base_addr;
        lines_cfg <= cfg_lines;
        lines_written <= '0;
        idx <= '0;
        sram_data_a <= '0;
      end
      if (accept) begin
        sram_data_a[idx*WORD_WIDTH +: WORD_WIDTH] <= in_data;
        idx <= idx + 1'b1;
      end
      if (state == WRITE) begin
        sram_data_a <= '0;
        idx <= '0;
        lines_written <= lines_written + 1'b1;
        sram_address_a <= sram_address_a == AW'(DEPTH - 1) ? '0 : sram_address_a + 1'b1;
      end
    end
  end
endmodule
